iob_master: RTL and testbench
=============================

IOB_MASTER -- requirements
Module: iob_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning CLK cycles in WAIT without termination before a local bus error.
REQ-002 SHALL have port CLK  in  1  I/O-bus clock (C8M); all logic on posedge.
REQ-003 SHALL have port RST  in  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports IOREQ, IORW, IOL0, IOU0  in  1 each  request, read(1)/write(0), low/upper strobe enables from the I/O bridge FIFO primary level.
REQ-005 SHALL have ports nDTACK, nBERR, nVPA  in  1 each  I/O bus terminations, active-low, asynchronous.
REQ-006 SHALL have ports nAS, nLDS, nUDS, nR_W  out  1 each  I/O bus strobes, active-low.
REQ-007 SHALL have ports IOACT, IODONE, nBERR_IOB  out  1 each  cycle active, done pulse, error status to bridge.
REQ-008 SHALL have ports nDoutOE  out  1  write data drive enable (active-low); E, nVMA  out  1 each  6800 E clock and valid memory address.

Function
REQ-009 SHALL double-register nDTACK, nBERR and nVPA on posedge CLK before use (2-cycle synchronizer).
REQ-010 SHALL implement states IDLE, ASRT, WAIT, TERM, RECV (encoding from package).
REQ-011 IDLE: when IOREQ=1, go to ASRT; latch IORW, IOL0, IOU0 into cycle registers; else stay.
REQ-012 ASRT: nAS=0, IOACT=1, nR_W=latched IORW; reads assert nLDS/nUDS per latched enables this cycle; go to WAIT.
REQ-013 WAIT: writes assert nDoutOE=0 in ASRT and nLDS/nUDS from first WAIT cycle; timeout counter increments each WAIT cycle.
REQ-014 WAIT exit priority: synced nBERR low, then synced nDTACK low, then timeout reached (counter==TIMEOUT_CYC), then synced nVPA low (VPA path); go to TERM with error flag set for BERR or timeout.
REQ-015 TERM: keep strobes one further cycle, then nAS, nLDS, nUDS go high and nDoutOE goes high; IODONE=1 for exactly this cycle; nBERR_IOB=0 if error flag; go to RECV.
REQ-016 RECV: IOACT=0, all strobes high; nBERR_IOB held from TERM until next ASRT; go to IDLE; minimum one IDLE cycle between cycles.
REQ-017 IOREQ changes while IOACT=1 SHALL be ignored; IOREQ still high in IDLE starts a new cycle.
REQ-018 nDTACK and nBERR asserted in the same synced sample SHALL yield error termination.
REQ-019 Timeout counter SHALL be 8 bits, cleared in ASRT, saturating at TIMEOUT_CYC.

Reset
REQ-020 RST SHALL force IDLE from any state, including mid-cycle, with nAS=nLDS=nUDS=nR_W=nDoutOE=nBERR_IOB=nVMA=1, IOACT=IODONE=E=0, counters 0, synchronizers to 1.

Configuration
REQ-021 Macro IOBM_VPA_EN defined: E divider runs (period 10 CLK, high 4, low 6); on VPA exit from WAIT, wait for E low-phase count 3, assert nVMA=0, go to TERM on last E-high cycle; nVMA high in RECV.
REQ-022 Macro IOBM_VPA_EN undefined: nVPA ignored, E=0, nVMA=1 constant; no divider logic.

Structure
REQ-023 Package iob_pkg SHALL hold the state enum, E period/phase constants and default timeout.
REQ-024 Sub-module iob_eclk (E divider with phase count output) SHALL be instantiated only under IOBM_VPA_EN.

Verification
REQ-025 Read: IOREQ=1, IORW=1, IOL0=IOU0=1, nDTACK low 3 cycles after nAS -> nAS/nLDS/nUDS low same cycle, IODONE one pulse, nBERR_IOB=1, IOACT low in RECV.
REQ-026 Write low byte: IORW=0, IOL0=1, IOU0=0 -> nDoutOE low in ASRT, nLDS low one cycle after nAS, nUDS high throughout.
REQ-027 No termination -> after 255 WAIT cycles TERM, nBERR_IOB=0, IODONE pulse; next cycle clears nBERR_IOB at ASRT.
REQ-028 nDTACK and nBERR low same cycle -> error termination, nBERR_IOB=0.
REQ-029 RST asserted in WAIT -> next cycle all outputs at reset values, IOREQ high afterwards starts a clean cycle.
REQ-030 IOBM_VPA_EN build, nVPA low -> nVMA low aligned to E phase 3, termination at end of E high, IODONE single pulse.

Source files
------------

// File: rtl/iob_pkg.sv
// Shared types and constants for the I/O-bus master: FSM state encoding,
// timeout default and 6800 E-clock timing.
package iob_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StAsrt = 3'd1,
        StWait = 3'd2,
        StTerm = 3'd3,
        StRecv = 3'd4
    } iob_state_e;

    localparam int unsigned IOB_TIMEOUT_DEF = 255;
    localparam int unsigned IOB_TO_W        = 8;

    // E clock: low phases 0..5, high phases 6..9
    localparam int unsigned E_PERIOD   = 10;
    localparam int unsigned E_HIGH_CYC = 4;
    localparam int unsigned E_LOW_CYC  = E_PERIOD - E_HIGH_CYC;
    localparam int unsigned E_PH_W     = 4;
    localparam int unsigned E_VMA_PH   = 3;

endpackage

// File: rtl/iob_eclk.sv
// 6800-style E clock divider; PH is the running phase count (low phases first).
import iob_pkg::*;

module iob_eclk (
    input  logic              CLK,
    input  logic              RST,
    output logic              E,
    output logic [E_PH_W-1:0] PH
);

    logic [E_PH_W-1:0] ph_q, ph_d;

    always_comb begin
        ph_d = ph_q + E_PH_W'(1);
        if (ph_q == E_PH_W'(E_PERIOD - 1)) begin
            ph_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

    assign PH = ph_q;
    assign E  = (ph_q >= E_PH_W'(E_LOW_CYC));

endmodule

// File: rtl/iob_master.sv
// I/O-bus cycle master: drives 68000-style strobes for one bridge request at a time.
// Optional VPA/E-clock path is built only when IOBM_VPA_EN is defined.
import iob_pkg::*;

module iob_master #(
    parameter int unsigned TIMEOUT_CYC = IOB_TIMEOUT_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic IOREQ,
    input  logic IORW,
    input  logic IOL0,
    input  logic IOU0,
    input  logic nDTACK,
    input  logic nBERR,
    input  logic nVPA,
    output logic nAS,
    output logic nLDS,
    output logic nUDS,
    output logic nR_W,
    output logic IOACT,
    output logic IODONE,
    output logic nBERR_IOB,
    output logic nDoutOE,
    output logic E,
    output logic nVMA
);

    localparam logic [IOB_TO_W-1:0] TO_VAL = IOB_TO_W'(TIMEOUT_CYC);

    iob_state_e state_q, state_d;

    logic [1:0] dtack_sync_q, berr_sync_q, vpa_sync_q;
    logic       dtack_s, berr_s, vpa_s;

    logic rw_q, rw_d;
    logic l0_q, l0_d;
    logic u0_q, u0_d;
    logic berr_iob_q, berr_iob_d;

    logic [IOB_TO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic                timeout_hit;

    // Two-flop synchronizers, idle (high) out of reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            dtack_sync_q <= 2'b11;
            berr_sync_q  <= 2'b11;
            vpa_sync_q   <= 2'b11;
        end else begin
            dtack_sync_q <= {dtack_sync_q[0], nDTACK};
            berr_sync_q  <= {berr_sync_q[0], nBERR};
            vpa_sync_q   <= {vpa_sync_q[0], nVPA};
        end
    end

    assign dtack_s = dtack_sync_q[1];
    assign berr_s  = berr_sync_q[1];
    assign vpa_s   = vpa_sync_q[1];

    // The count includes the current WAIT cycle, so exit happens on the
    // TIMEOUT_CYC-th WAIT cycle.
    always_comb begin
        cnt_inc = cnt_q;
        if (cnt_q != TO_VAL) begin
            cnt_inc = cnt_q + IOB_TO_W'(1);
        end
        timeout_hit = (cnt_inc == TO_VAL);
    end

`ifdef IOBM_VPA_EN
    localparam logic [E_PH_W-1:0] PH_VMA_PRE  = E_PH_W'(E_VMA_PH - 1);
    localparam logic [E_PH_W-1:0] PH_TERM_PRE = E_PH_W'(E_PERIOD - 2);

    logic [E_PH_W-1:0] e_ph;
    logic              vpa_q, vpa_d;
    logic              nvma_q, nvma_d;

    iob_eclk u_eclk (
        .CLK (CLK),
        .RST (RST),
        .E   (E),
        .PH  (e_ph)
    );

    assign nVMA = nvma_q;
`else
    logic unused_vpa;
    assign unused_vpa = vpa_s;
    assign E          = 1'b0;
    assign nVMA       = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        l0_d       = l0_q;
        u0_d       = u0_q;
        berr_iob_d = berr_iob_q;
        cnt_d      = cnt_q;
`ifdef IOBM_VPA_EN
        vpa_d      = vpa_q;
        nvma_d     = nvma_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (IOREQ) begin
                    state_d    = StAsrt;
                    rw_d       = IORW;
                    l0_d       = IOL0;
                    u0_d       = IOU0;
                    berr_iob_d = 1'b1;
                end
            end
            StAsrt: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_inc;
                if (!berr_s) begin
                    berr_iob_d = 1'b0;
                    state_d    = StTerm;
                end else if (!dtack_s) begin
                    state_d = StTerm;
                end else if (timeout_hit) begin
                    berr_iob_d = 1'b0;
                    state_d    = StTerm;
                end
`ifdef IOBM_VPA_EN
                else if (!vpa_s || vpa_q) begin
                    // VMA lands on E low phase 3; TERM occupies the last E-high cycle
                    vpa_d = 1'b1;
                    if (nvma_q && e_ph == PH_VMA_PRE) begin
                        nvma_d = 1'b0;
                    end else if (!nvma_q && e_ph == PH_TERM_PRE) begin
                        state_d = StTerm;
                    end
                end
`endif
            end
            StTerm: begin
                state_d = StRecv;
`ifdef IOBM_VPA_EN
                nvma_d  = 1'b1;
                vpa_d   = 1'b0;
`endif
            end
            StRecv: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            rw_q       <= 1'b1;
            l0_q       <= 1'b0;
            u0_q       <= 1'b0;
            berr_iob_q <= 1'b1;
            cnt_q      <= '0;
`ifdef IOBM_VPA_EN
            vpa_q      <= 1'b0;
            nvma_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            l0_q       <= l0_d;
            u0_q       <= u0_d;
            berr_iob_q <= berr_iob_d;
            cnt_q      <= cnt_d;
`ifdef IOBM_VPA_EN
            vpa_q      <= vpa_d;
            nvma_q     <= nvma_d;
`endif
        end
    end

    // Outputs decode purely from registered state, so they are glitch-free
    always_comb begin
        nAS     = 1'b1;
        nLDS    = 1'b1;
        nUDS    = 1'b1;
        nR_W    = 1'b1;
        nDoutOE = 1'b1;
        IOACT   = 1'b0;
        IODONE  = 1'b0;
        unique case (state_q)
            StAsrt: begin
                nAS   = 1'b0;
                IOACT = 1'b1;
                nR_W  = rw_q;
                if (rw_q) begin
                    nLDS = ~l0_q;
                    nUDS = ~u0_q;
                end else begin
                    nDoutOE = 1'b0;
                end
            end
            StWait, StTerm: begin
                nAS     = 1'b0;
                IOACT   = 1'b1;
                nR_W    = rw_q;
                nLDS    = ~l0_q;
                nUDS    = ~u0_q;
                nDoutOE = rw_q;
                IODONE  = (state_q == StTerm);
            end
            default: begin
            end
        endcase
    end

    assign nBERR_IOB = berr_iob_q;

endmodule

// File: tb/tb_iob_master.sv
// Table-driven bench for iob_master plus hand sequences for timeout and,
// when IOBM_VPA_EN is defined, the VPA/E-clock path.
module tb_iob_master;

    logic CLK = 1'b0;
    logic RST, IOREQ, IORW, IOL0, IOU0, nDTACK, nBERR, nVPA;
    logic nAS, nLDS, nUDS, nR_W, IOACT, IODONE, nBERR_IOB, nDoutOE, E, nVMA;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] stim; // {RST,IOREQ,IORW,IOL0,IOU0,nDTACK,nBERR,nVPA}
        logic [7:0] exp;  // {nAS,nLDS,nUDS,nR_W,nDoutOE,IOACT,IODONE,nBERR_IOB}
    } vec_t;

    vec_t vecs[$];

    iob_master #(.TIMEOUT_CYC(255)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IOREQ     (IOREQ),
        .IORW      (IORW),
        .IOL0      (IOL0),
        .IOU0      (IOU0),
        .nDTACK    (nDTACK),
        .nBERR     (nBERR),
        .nVPA      (nVPA),
        .nAS       (nAS),
        .nLDS      (nLDS),
        .nUDS      (nUDS),
        .nR_W      (nR_W),
        .IOACT     (IOACT),
        .IODONE    (IODONE),
        .nBERR_IOB (nBERR_IOB),
        .nDoutOE   (nDoutOE),
        .E         (E),
        .nVMA      (nVMA)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] outs();
        return {nAS, nLDS, nUDS, nR_W, nDoutOE, IOACT, IODONE, nBERR_IOB};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] s);
        {RST, IOREQ, IORW, IOL0, IOU0, nDTACK, nBERR, nVPA} = s;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        drive(8'b0000_0111);

        //           stim          exp
        vecs.push_back('{8'b1000_0111, 8'b1111_1001}); // reset
        vecs.push_back('{8'b0111_1111, 8'b0001_1101}); // read both -> ASRT
        vecs.push_back('{8'b0000_0011, 8'b0001_1101}); // WAIT, nDTACK low
        vecs.push_back('{8'b0100_0011, 8'b0001_1101}); // WAIT, IOREQ ignored
        vecs.push_back('{8'b0000_0111, 8'b0001_1111}); // TERM
        vecs.push_back('{8'b0100_0111, 8'b1111_1001}); // RECV
        vecs.push_back('{8'b0100_0111, 8'b1111_1001}); // IDLE gap
        vecs.push_back('{8'b0101_0111, 8'b0110_0101}); // write low -> ASRT
        vecs.push_back('{8'b0000_0011, 8'b0010_0101}); // WAIT, nLDS low
        vecs.push_back('{8'b0000_0011, 8'b0010_0101});
        vecs.push_back('{8'b0000_0111, 8'b0010_0111}); // TERM
        vecs.push_back('{8'b0000_0111, 8'b1111_1001}); // RECV
        vecs.push_back('{8'b0000_0111, 8'b1111_1001}); // IDLE
        vecs.push_back('{8'b0110_1111, 8'b0101_1101}); // read upper -> ASRT
        vecs.push_back('{8'b0010_1001, 8'b0101_1101}); // DTACK+BERR together
        vecs.push_back('{8'b0010_1001, 8'b0101_1101});
        vecs.push_back('{8'b0000_0111, 8'b0101_1110}); // TERM with error
        vecs.push_back('{8'b0100_0111, 8'b1111_1000}); // RECV, error held
        vecs.push_back('{8'b0100_0111, 8'b1111_1000}); // IDLE, error held
        vecs.push_back('{8'b0111_1111, 8'b0001_1101}); // ASRT clears error
        vecs.push_back('{8'b0000_0111, 8'b0001_1101}); // WAIT
        vecs.push_back('{8'b1111_1111, 8'b1111_1001}); // reset mid-cycle
        vecs.push_back('{8'b0101_1111, 8'b0110_0101}); // write both -> ASRT
        vecs.push_back('{8'b0001_1011, 8'b0000_0101});
        vecs.push_back('{8'b0001_1011, 8'b0000_0101});
        vecs.push_back('{8'b0000_0111, 8'b0000_0111}); // TERM
        vecs.push_back('{8'b0000_0111, 8'b1111_1001}); // RECV
        vecs.push_back('{8'b0000_0111, 8'b1111_1001}); // IDLE

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stim);
            tick();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Timeout: no termination at all; nVPA low must be ignored without the VPA build
`ifdef IOBM_VPA_EN
        drive(8'b0111_1111);
`else
        drive(8'b0111_1110);
`endif
        tick();
        chk("to_asrt_act", 32'(IOACT), 32'd1);
        IOREQ = 1'b0;
        n = 1;
        while (n <= 400) begin
            tick();
            if (IODONE) break;
            n++;
        end
        chk("to_wait_len", n, 32'd256);
        chk("to_term_berr", 32'(nBERR_IOB), 32'd0);
`ifndef IOBM_VPA_EN
        chk("novpa_e", 32'(E), 32'd0);
        chk("novpa_vma", 32'(nVMA), 32'd1);
`endif
        tick();
        chk("to_recv", 32'({IOACT, IODONE, nBERR_IOB}), 32'b000);
        drive(8'b0111_1111);
        tick();
        chk("to_idle_held", 32'(nBERR_IOB), 32'd0);
        tick();
        chk("to_next_asrt", 32'({nAS, IOACT, nBERR_IOB}), 32'b011);
        drive(8'b0000_0011);
        for (int k = 0; k < 4; k++) tick();
        drive(8'b0000_0111);
        for (int k = 0; k < 3; k++) tick();
        chk("to_after_idle", 32'(outs()), 32'h F9);

`ifdef IOBM_VPA_EN
        begin
            logic [3:0] e_hist;
            int vma_at, done_at;
            e_hist  = '0;
            vma_at  = -1;
            done_at = -1;
            for (int k = 0; k < 4; k++) begin
                tick();
                e_hist = {e_hist[2:0], E};
            end
            drive(8'b0111_1110);
            for (int k = 0; k < 60; k++) begin
                tick();
                IOREQ = 1'b0;
                if (!nVMA && vma_at < 0) begin
                    vma_at = k;
                    chk("vpa_vma_elow", 32'(E), 32'd0);
                    chk("vpa_vma_phase", 32'(e_hist), 32'b1000);
                end
                if (IODONE) begin
                    done_at = k;
                    chk("vpa_term_ehigh", 32'(E), 32'd1);
                    chk("vpa_term_berr", 32'(nBERR_IOB), 32'd1);
                    break;
                end
                e_hist = {e_hist[2:0], E};
            end
            chk("vpa_vma_to_term", done_at - vma_at, 32'd6);
            nVPA = 1'b1;
            tick();
            chk("vpa_recv", 32'({E, IODONE, nVMA, IOACT}), 32'b0010);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
